// File: rtl/timer_prescaler_mc.sv
// Shared prescaler for NUM_CH timer channels, emitting one-cycle count-enable ticks.
// Optional macro PRESC_CLR_ON_CS_EN: a cs change on any channel clears the counter like psr.
module timer_prescaler_mc #(
   parameter int NUM_CH      = 2,
   parameter int PRESC_W     = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  sysClock,
   input  logic                  rst_n,
   input  logic [3*NUM_CH-1:0]   cs,
   input  logic                  psr,
   input  logic [NUM_CH-1:0]     t_pin,
   output logic [NUM_CH-1:0]     tick,
   output logic [PRESC_W-1:0]    presc_cnt
);

   localparam int PRIME_MAX = SYNC_STAGES + 1;
   localparam int PRIME_W   = $clog2(PRIME_MAX + 1);

   logic [PRESC_W-1:0]     cnt_q;
   logic [PRIME_W-1:0]     prime_q;
   logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
   logic [NUM_CH-1:0]      dly_q;
   logic [NUM_CH-1:0]      tick_d;
   logic                   primed;
   logic                   clr;

`ifdef PRESC_CLR_ON_CS_EN
   logic [3*NUM_CH-1:0] cs_hist_q;

   always_ff @(posedge sysClock or negedge rst_n) begin
      if (!rst_n) cs_hist_q <= '0;
      else        cs_hist_q <= cs;
   end

   assign clr = psr | (cs != cs_hist_q);
`else
   assign clr = psr;
`endif

   // External edges are ignored until the synchroniser has flushed its reset zeros.
   assign primed = (prime_q == PRIME_W'(PRIME_MAX));

   always_comb begin
      tick_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         case (cs[3*i +: 3])
            3'b000: tick_d[i] = 1'b0;
            3'b001: tick_d[i] = 1'b1;
            3'b010: tick_d[i] = !clr && (cnt_q[2:0] == 3'h7);
            3'b011: tick_d[i] = !clr && (cnt_q[5:0] == 6'h3f);
            3'b100: tick_d[i] = !clr && (cnt_q[7:0] == 8'hff);
            3'b101: tick_d[i] = !clr && (cnt_q[9:0] == 10'h3ff);
            3'b110: tick_d[i] = primed && dly_q[i] && !sync_q[i][SYNC_STAGES-1];
            default: tick_d[i] = primed && !dly_q[i] && sync_q[i][SYNC_STAGES-1];
         endcase
      end
   end

   always_ff @(posedge sysClock or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         prime_q <= '0;
         dly_q   <= '0;
         tick    <= '0;
         for (int i = 0; i < NUM_CH; i++) sync_q[i] <= '0;
      end else begin
         cnt_q <= clr ? '0 : cnt_q + PRESC_W'(1);
         if (!primed) prime_q <= prime_q + PRIME_W'(1);
         for (int i = 0; i < NUM_CH; i++) begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], t_pin[i]};
            dly_q[i]  <= sync_q[i][SYNC_STAGES-1];
         end
         tick <= tick_d;
      end
   end

   assign presc_cnt = cnt_q;

endmodule

// File: tb/tb_timer_prescaler_mc.sv
// Directed bench for timer_prescaler_mc: divided ticks, psr, external edges, priming, cs switching.
module tb_timer_prescaler_mc;

   logic       sysClock;
   logic       rst_n;
   logic [5:0] cs;
   logic       psr;
   logic [1:0] t_pin;
   logic [1:0] tick;
   logic [9:0] presc_cnt;

   int errors = 0;
   int checks = 0;

`ifdef PRESC_CLR_ON_CS_EN
   localparam int OFS  = 1;
   localparam int SW_J = 65;
`else
   localparam int OFS  = 0;
   localparam int SW_J = 28;
`endif

   timer_prescaler_mc #(.NUM_CH(2), .PRESC_W(10), .SYNC_STAGES(2)) dut (
      .sysClock (sysClock),
      .rst_n    (rst_n),
      .cs       (cs),
      .psr      (psr),
      .t_pin    (t_pin),
      .tick     (tick),
      .presc_cnt(presc_cnt)
   );

   initial begin
      sysClock = 1'b0;
      forever #5 sysClock = ~sysClock;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sysClock);
      #1;
   endtask

   task automatic apply_reset(input logic [5:0] c, input logic [1:0] tp);
      rst_n = 1'b0;
      cs    = c;
      t_pin = tp;
      psr   = 1'b0;
      repeat (2) @(posedge sysClock);
      #1;
      rst_n = 1'b1;
   endtask

   // One psr edge right after release aligns the counter to 0 in every build.
   task automatic prime_step();
      psr = 1'b1;
      step();
      psr = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1;
      cs    = '0;
      psr   = 1'b0;
      t_pin = '0;
      #2;
      rst_n = 1'b0;
      cs    = {3'b101, 3'b010};
      repeat (2) @(posedge sysClock);
      #1;
      check("reset_cnt", 32'(presc_cnt), 32'd0);
      check("reset_tick", 32'(tick), 32'd0);
      rst_n = 1'b1;

      // /8 on ch0 and /1024 on ch1 from reset release
      for (int k = 1; k <= 2048; k++) begin
         step();
         check("div8_tick0", 32'(tick[0]), 32'((k > OFS) && ((k - OFS) % 8 == 0)));
         check("div1024_tick1", 32'(tick[1]), 32'((k > OFS) && ((k - OFS) % 1024 == 0)));
         if (k >= 1023 && k <= 1025)
            check("wrap_cnt", 32'(presc_cnt), 32'((k - OFS) % 1024));
      end

      // clk/1 then stop
      cs = {3'b000, 3'b001};
      for (int j = 1; j <= 5; j++) begin
         step();
         check("clk1_tick0", 32'(tick[0]), 32'd1);
      end
      cs = {3'b000, 3'b000};
      for (int j = 1; j <= 5; j++) begin
         step();
         check("stop_tick0", 32'(tick[0]), 32'd0);
      end

      // psr on /64, clk/1 on ch1 must not be affected
      apply_reset({3'b001, 3'b011}, 2'b00);
      prime_step();
      repeat (40) step();
      check("psr_pre_cnt", 32'(presc_cnt), 32'd40);
      psr = 1'b1;
      step();
      psr = 1'b0;
      check("psr_tick0", 32'(tick[0]), 32'd0);
      check("psr_tick1", 32'(tick[1]), 32'd1);
      check("psr_cnt", 32'(presc_cnt), 32'd0);
      for (int j = 1; j <= 64; j++) begin
         step();
         check("after_psr_tick0", 32'(tick[0]), 32'(j == 64));
      end
      repeat (63) step();
      check("psr63_pre_cnt", 32'(presc_cnt), 32'd127);
      psr = 1'b1;
      step();
      psr = 1'b0;
      check("psr63_suppress", 32'(tick[0]), 32'd0);
      check("psr63_tick1", 32'(tick[1]), 32'd1);
      check("psr63_cnt", 32'(presc_cnt), 32'd0);

      // external rising then falling on ch1
      apply_reset({3'b111, 3'b000}, 2'b00);
      prime_step();
      repeat (5) step();
      t_pin[1] = 1'b1;
      for (int j = 1; j <= 6; j++) begin
         step();
         check("ext_rise_tick1", 32'(tick[1]), 32'(j == 3));
      end
      cs[5:3] = 3'b110;
      for (int j = 1; j <= 4; j++) begin
         step();
         check("ext_fall_idle", 32'(tick[1]), 32'd0);
      end
      t_pin[1] = 1'b0;
      for (int j = 1; j <= 6; j++) begin
         step();
         check("ext_fall_tick1", 32'(tick[1]), 32'(j == 3));
      end
      t_pin[1] = 1'b1;
      for (int j = 1; j <= 6; j++) begin
         step();
         check("ext_fall_ignores_rise", 32'(tick[1]), 32'd0);
      end

      // reset mid-operation kills a tick in flight
      cs = {3'b000, 3'b001};
      step();
      check("midrst_pre_tick0", 32'(tick[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_tick", 32'(tick), 32'd0);
      check("midrst_cnt", 32'(presc_cnt), 32'd0);

      // pin held high through reset must not tick during priming
      cs    = {3'b000, 3'b111};
      t_pin = 2'b01;
      repeat (2) @(posedge sysClock);
      #1;
      rst_n = 1'b1;
      for (int j = 1; j <= 10; j++) begin
         step();
         check("prime_no_tick0", 32'(tick[0]), 32'd0);
      end
      t_pin[0] = 1'b0;
      for (int j = 1; j <= 5; j++) begin
         step();
         check("prime_fall_no_tick0", 32'(tick[0]), 32'd0);
      end
      t_pin[0] = 1'b1;
      for (int j = 1; j <= 5; j++) begin
         step();
         check("prime_real_rise", 32'(tick[0]), 32'(j == 3));
      end

      // cs switch /8 -> /64 at presc_cnt=100
      apply_reset({3'b000, 3'b010}, 2'b00);
      prime_step();
      repeat (100) step();
      check("sw_pre_cnt", 32'(presc_cnt), 32'd100);
      cs[2:0] = 3'b011;
      for (int j = 1; j <= 70; j++) begin
         step();
         check("sw_tick0", 32'(tick[0]), 32'(j == SW_J));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
